axi_read_master: RTL
====================

Name: axi_read_master

Overview:
- AXI4 read-channel master that drives the AR/R ports of `axi_slave_ram`, which sits directly downstream.
- Accepts one burst command at a time from a simple valid/ready command port and issues one INCR burst on AR.
- Collects the R beats into a one-entry output register and streams them out on a valid/ready data port with a last flag.
- Reports per-burst completion (`done`) and error (`err`).

Parameters:
- ADDRESS_WIDTH, 8, width of `cmd_addr` and `araddr`.
- DATA_WIDTH, 32, width of `rdata` and `out_data`.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- cmd_addr  in  ADDRESS_WIDTH  burst start address.
- cmd_len  in  8  beats minus one (AXI arlen encoding).
- cmd_size  in  3  bytes-per-beat code (AXI arsize encoding).
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted this cycle when both high.
- araddr  out  ADDRESS_WIDTH  read address.
- arlen  out  8  burst length.
- arsize  out  3  beat size.
- arburst  out  2  burst type; constant 2'b01 (INCR).
- arvalid  out  1  address valid.
- arready  in  1  address ready from slave.
- rdata  in  DATA_WIDTH  read data.
- rresp  in  2  read response.
- rlast  in  1  last beat of burst.
- rvalid  in  1  read data valid.
- rready  out  1  master ready for a beat.
- out_data  out  DATA_WIDTH  registered beat data.
- out_last  out  1  registered rlast of that beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream consumer ready.
- done  out  1  one-cycle pulse when the burst's rlast beat is accepted.
- err  out  1  sticky burst error; valid with `done`, held until the next command is accepted.

Behaviour:
- Reset (async assert, synchronous-to-aclk release):
  - state=IDLE.
  - arvalid, rready, out_valid, out_last, done, err = 0.
  - araddr, arlen, arsize, out_data = 0.
  - arburst=2'b01.
  - Beat counter = 0.
- cmd_ready is 1 exactly when state==IDLE. It is decoded from state, so it reads 1 while in reset. A command is accepted only on a rising edge with aresetn=1.
- FSM states and transitions:
  - IDLE:
    - On cmd_valid&&cmd_ready: latch the command into araddr/arlen/arsize, clear err and the beat counter, go to ADDR.
    - arvalid rises the cycle after acceptance.
  - ADDR:
    - arvalid=1; araddr, arlen and arsize are held stable until arready is sampled high.
    - On arvalid&&arready: arvalid=0 next cycle, go to DATA.
  - DATA:
    - rready = (state==DATA) && (!out_valid || out_ready). This is combinational and gives full throughput of one beat per cycle while out_ready=1.
    - On rvalid&&rready: out_data<=rdata, out_last<=rlast, out_valid<=1, and the beat counter increments (8-bit, saturates at 255).
    - If rresp!=2'b00 on any accepted beat: err<=1.
    - If the accepted beat has rlast=1: done<=1 for exactly one cycle, go to IDLE.
    - Beats with rvalid=0 or rready=0 cause no change.
- Output register:
  - out_valid clears on out_valid&&out_ready unless a new beat loads in the same cycle.
  - Simultaneous drain and load keeps out_valid=1 with the new data.
  - A held beat is never overwritten, because rready=0 while out_valid&&!out_ready.
- Last-beat drain: the final beat may still be pending on the output after done. IDLE may accept a new command meanwhile, but no new R beat is taken until the output register drains.
- Latency:
  - Command accept → arvalid: 1 cycle.
  - R handshake → out_valid: 1 cycle.
  - rlast handshake → done: 1 cycle.
- Reset mid-operation: everything returns to reset values immediately. Any pending output beat is discarded; no done pulse is issued.

Optional Feature:
- Macro: AXI_RD_BEAT_CHECK_EN.
- Defined — beat-count protocol check:
  - err<=1 if an accepted beat has rlast=1 while the counter value before increment != arlen (early last).
  - err<=1 if an accepted beat has rlast=0 while the counter already equals arlen (missing last).
  - Either way the burst still ends only on rlast.
- Undefined: the check logic is absent and err reflects rresp only.

Test Plan:
- Reset: hold aresetn=0 for 3 cycles → arvalid=0, rready=0, out_valid=0, done=0, err=0, arburst=2'b01, cmd_ready=1 after release.
- Nominal burst:
  - Stimulus: cmd addr=0, len=4, size=0; arready delayed 2 cycles.
  - araddr/arlen/arsize held at 0/4/0 until handshake.
  - 5 beats appear on out_data equal to the rdata sequence, out_last=1 only on the 5th.
  - done pulses once, err=0.
- Backpressure: out_ready toggled 1,0,0,1 during len=3 burst → rready=0 whenever out_valid&&!out_ready; exactly 4 beats out, none lost or duplicated, order preserved.
- Error response: rresp=2'b10 on beat 2 of a len=2 burst → err=1 at done. The next command acceptance clears err to 0.
- Early rlast: rlast on beat index 1 of len=4 → with AXI_RD_BEAT_CHECK_EN err=1; without it err=0. done pulses after that beat in both builds.
- Reset mid-burst: assert aresetn=0 after beat 2 of len=4 → outputs return to reset values asynchronously. A new cmd len=1 afterwards completes with 2 beats and done.

Source files
------------

// File: rtl/axi_read_master.sv
// AXI4 read-channel master: one INCR burst per command, R beats staged through a one-entry output register.
// Optional beat-count protocol check is compiled in when AXI_RD_BEAT_CHECK_EN is defined.
module axi_read_master #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  input  logic [2:0]               cmd_size,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic [ADDRESS_WIDTH-1:0] araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]               arlen_q, arlen_d;
  logic [2:0]               arsize_q, arsize_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;
  logic                     out_valid_q, out_valid_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [7:0]               beat_cnt_q, beat_cnt_d;
  logic                     r_hs;

  assign cmd_ready = (state_q == IDLE);
  assign arvalid   = (state_q == ADDR);
  assign arburst   = 2'b01;
  // A held output beat blocks the R channel so it can never be overwritten.
  assign rready    = (state_q == DATA) && (!out_valid_q || out_ready);
  assign r_hs      = rvalid && rready;

  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = arsize_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    err_d       = err_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          araddr_d   = cmd_addr;
          arlen_d    = cmd_len;
          arsize_d   = cmd_size;
          err_d      = 1'b0;
          beat_cnt_d = 8'd0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (arready) state_d = DATA;
      end
      DATA: begin
        if (r_hs) begin
          if (rresp != 2'b00) err_d = 1'b1;
`ifdef AXI_RD_BEAT_CHECK_EN
          if (rlast && (beat_cnt_q != arlen_q)) err_d = 1'b1;
          if (!rlast && (beat_cnt_q == arlen_q)) err_d = 1'b1;
`endif
          if (beat_cnt_q != 8'hff) beat_cnt_d = beat_cnt_q + 8'd1;
          if (rlast) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load in the same cycle as a drain keeps the register full with the new beat.
    if (r_hs) begin
      out_data_d  = rdata;
      out_last_d  = rlast;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

endmodule
